// File: rtl/famicom_pad_poller_if.sv
// Serial pad lines plus the parallel button word presented to the host.
interface famicom_pad_poller_if;
    logic       famicom_latch;
    logic       famicom_pulse;
    logic       famicom_data;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic       buttons_changed;

    modport master (
        output famicom_latch,
        output famicom_pulse,
        input  famicom_data,
        output buttons,
        output buttons_valid,
        output buttons_changed
    );

    modport slave (
        input  famicom_latch,
        input  famicom_pulse,
        output famicom_data,
        input  buttons,
        input  buttons_valid,
        input  buttons_changed
    );
endinterface

// File: rtl/famicom_pad_poller.sv
// Host-side Famicom controller poller: drives latch/pulse, shifts in 8 serial bits,
// publishes them as an active-high button word with valid/changed strobes.
module famicom_pad_poller #(
    parameter int LATCH_CYC = 1200,
    parameter int HALF_CYC  = 600,
    parameter int POLL_CYC  = 1666667,
    parameter int CNT_W     = 21
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 poll_now,
    output logic                 busy,
    famicom_pad_poller_if.master pad
);

    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_GAP, S_PHI, S_PLO, S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] phase;
    logic [2:0]       index;
    logic [7:0]       shift;
    logic [7:0]       word_new;
    logic [1:0]       sync;
    logic             data_s;
    logic             trigger;
    logic             phase_last;
    logic             sample;
    logic             last_bit;
    logic             latch_d;
    logic             pulse_d;
    logic             busy_d;
    logic             valid_d;

    assign data_s  = sync[1];
    assign trigger = enable && (timer == POLL_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], pad.famicom_data};
        end
    end

    // Free-running poll timer; holding it at 0 while disabled restarts the period cleanly.
    always_ff @(posedge clk_sys) begin
        if (reset || !enable) begin
            timer <= '0;
        end else if (timer == POLL_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_comb begin
        phase_last = 1'b0;
        case (state)
            S_LATCH:             phase_last = (phase == LATCH_LAST);
            S_GAP, S_PHI, S_PLO: phase_last = (phase == HALF_LAST);
            default:             phase_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (trigger || poll_now) state_next = S_LATCH;
            S_LATCH: if (phase_last) state_next = S_GAP;
            S_GAP:   if (phase_last) state_next = S_PHI;
            S_PHI:   if (phase_last) state_next = S_PLO;
            S_PLO:   if (phase_last) state_next = (index == 3'd7) ? S_DONE : S_PHI;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave flops aligned with the state.
    always_comb begin
        latch_d = (state_next == S_LATCH);
        pulse_d = (state_next == S_PHI);
        busy_d  = (state_next != S_IDLE);
        valid_d = (state_next == S_DONE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pad.famicom_latch <= 1'b0;
            pad.famicom_pulse <= 1'b0;
            pad.buttons_valid <= 1'b0;
            busy              <= 1'b0;
        end else begin
            pad.famicom_latch <= latch_d;
            pad.famicom_pulse <= pulse_d;
            pad.buttons_valid <= valid_d;
            busy              <= busy_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || (state_next != state) || (state == S_IDLE)) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign sample   = phase_last && ((state == S_GAP) || (state == S_PLO));
    assign last_bit = phase_last && (state == S_PLO) && (index == 3'd7);

    // Merge the current sample so the bit-7 value is published on the same edge it is taken.
    always_comb begin
        word_new = shift;
        if (sample) begin
            if (state == S_GAP) begin
                word_new[0] = data_s;
            end else begin
                word_new[index] = data_s;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            shift               <= 8'hFF;
            index               <= 3'd0;
            pad.buttons         <= 8'h00;
            pad.buttons_changed <= 1'b0;
        end else begin
            pad.buttons_changed <= 1'b0;
            if (sample) begin
                shift <= word_new;
            end
            if (phase_last && (state == S_GAP)) begin
                index <= 3'd1;
            end else if (phase_last && (state == S_PLO) && (index != 3'd7)) begin
                index <= index + 3'd1;
            end
            if (last_bit) begin
                pad.buttons         <= ~word_new;
                pad.buttons_changed <= (~word_new != pad.buttons);
            end
        end
    end

endmodule

// File: tb/tb_famicom_pad_poller.sv
// Scoreboard bench for famicom_pad_poller with a shift-register responder model.
module tb_famicom_pad_poller;

    logic clk_sys = 1'b0;
    logic reset;
    logic enable;
    logic poll_now;
    logic busy;

    famicom_pad_poller_if pad_if ();

    famicom_pad_poller #(
        .LATCH_CYC (4),
        .HALF_CYC  (4),
        .POLL_CYC  (200),
        .CNT_W     (21)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .enable   (enable),
        .poll_now (poll_now),
        .busy     (busy),
        .pad      (pad_if.master)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk_sys) cyc++;

    // Responder: loads while latch is high, shifts right on pulse rise, drives bit 0.
    logic [7:0] resp_word = 8'hFF;
    logic [7:0] resp_sr = 8'hFF;
    logic       resp_pulse_q = 1'b0;

    always @(posedge clk_sys) begin
        resp_pulse_q <= pad_if.famicom_pulse;
        if (pad_if.famicom_latch) begin
            resp_sr <= resp_word;
        end else if (pad_if.famicom_pulse && !resp_pulse_q) begin
            resp_sr <= {1'b1, resp_sr[7:1]};
        end
    end

    assign pad_if.famicom_data = resp_sr[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a word is published.
    logic [8:0] exp_q[$];
    int rise_t[$];
    int valid_cnt = 0;
    int rise_cnt = 0;
    int cur_rise = 0;
    int latch_hi = 0;
    int pulse_n = 0;
    bit overlap = 1'b0;
    logic latch_prev = 1'b0;
    logic pulse_prev = 1'b0;
    logic valid_prev = 1'b0;

    always @(negedge clk_sys) begin
        logic [8:0] e;
        if (pad_if.famicom_latch && pad_if.famicom_pulse) overlap = 1'b1;
        if (pad_if.famicom_latch && !latch_prev) begin
            rise_cnt++;
            rise_t.push_back(cyc);
            cur_rise = cyc;
            latch_hi = 0;
            pulse_n  = 0;
        end
        if (pad_if.famicom_latch) latch_hi++;
        if (pad_if.famicom_pulse && !pulse_prev) pulse_n++;
        if (pad_if.buttons_changed && !pad_if.buttons_valid)
            check("changed_without_valid", 32'(pad_if.buttons_changed), 0);
        if (pad_if.buttons_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: buttons %02h published with no frame outstanding", pad_if.buttons);
            end else begin
                e = exp_q.pop_front();
                check("buttons", 32'(pad_if.buttons), 32'(e[7:0]));
                check("buttons_changed", 32'(pad_if.buttons_changed), 32'(e[8]));
            end
            check("frame_len", 32'(cyc - cur_rise + 1), 65);
            check("pulse_count", 32'(pulse_n), 7);
            check("latch_width", 32'(latch_hi), 4);
            check("valid_width", 32'(valid_prev), 0);
            check("latch_pulse_overlap", 32'(overlap), 0);
        end
        latch_prev = pad_if.famicom_latch;
        pulse_prev = pad_if.famicom_pulse;
        valid_prev = pad_if.buttons_valid;
    end

    task automatic wait_valid(input int n0, input int bound);
        int k = 0;
        while (valid_cnt == n0 && k < bound) begin
            @(negedge clk_sys);
            k++;
        end
        if (valid_cnt == n0) check("valid_timeout", 32'(valid_cnt - n0), 1);
    endtask

    task automatic wait_rise(input int target, input int bound);
        int k = 0;
        while (rise_cnt < target && k < bound) begin
            @(negedge clk_sys);
            k++;
        end
        if (rise_cnt < target) check("latch_timeout", 32'(rise_cnt), 32'(target));
    endtask

    task automatic pulse_poll();
        @(negedge clk_sys);
        poll_now = 1'b1;
        @(negedge clk_sys);
        poll_now = 1'b0;
    endtask

    task automatic do_poll(input logic [7:0] word, input logic [8:0] exp);
        int n0;
        resp_word = word;
        exp_q.push_back(exp);
        n0 = valid_cnt;
        pulse_poll();
        wait_valid(n0, 150);
        repeat (3) @(negedge clk_sys);
    endtask

    initial begin
        int r0, rt0, v0, t0, n0, k, falls;
        logic p_prev;

        reset = 1'b1;
        enable = 1'b0;
        poll_now = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_latch", 32'(pad_if.famicom_latch), 0);
        check("rst_pulse", 32'(pad_if.famicom_pulse), 0);
        check("rst_buttons", 32'(pad_if.buttons), 0);
        check("rst_valid", 32'(pad_if.buttons_valid), 0);
        check("rst_changed", 32'(pad_if.buttons_changed), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timer", 32'(dut.timer), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        do_poll(8'hFF, {1'b0, 8'h00});
        do_poll(8'hFA, {1'b1, 8'h05});
        do_poll(8'hFA, {1'b0, 8'h05});

        // Automatic polling for exactly 1000 enabled cycles.
        resp_word = 8'hC3;
        exp_q.push_back({1'b1, 8'h3C});
        repeat (4) exp_q.push_back({1'b0, 8'h3C});
        r0 = rise_cnt;
        rt0 = rise_t.size();
        @(negedge clk_sys);
        enable = 1'b1;
        repeat (1000) @(negedge clk_sys);
        enable = 1'b0;
        repeat (300) @(negedge clk_sys);
        check("auto_frames", 32'(rise_cnt - r0), 5);
        if (rise_t.size() >= rt0 + 5) begin
            for (int i = 1; i < 5; i++)
                check("poll_period", 32'(rise_t[rt0 + i] - rise_t[rt0 + i - 1]), 200);
        end
        repeat (300) @(negedge clk_sys);
        check("frames_after_disable", 32'(rise_cnt - r0), 5);
        check("timer_held", 32'(dut.timer), 0);

        // poll_now during PHI must be dropped without disturbing the timer schedule.
        exp_q.push_back({1'b0, 8'h3C});
        exp_q.push_back({1'b0, 8'h3C});
        r0 = rise_cnt;
        @(negedge clk_sys);
        enable = 1'b1;
        wait_rise(r0 + 1, 300);
        v0 = valid_cnt;
        t0 = rise_t[$];
        k = 0;
        while (!pad_if.famicom_pulse && k < 100) begin
            @(negedge clk_sys);
            k++;
        end
        check("pulse_seen", 32'(pad_if.famicom_pulse), 1);
        poll_now = 1'b1;
        @(negedge clk_sys);
        poll_now = 1'b0;
        wait_rise(r0 + 2, 300);
        check("period_after_ignored_poll", 32'(rise_t[$] - t0), 200);
        check("valids_between_rises", 32'(valid_cnt - v0), 1);
        n0 = valid_cnt;
        @(negedge clk_sys);
        enable = 1'b0;
        wait_valid(n0, 150);
        repeat (3) @(negedge clk_sys);

        // Reset during PLO of bit 4: nothing partial may be published.
        resp_word = 8'h0F;
        n0 = valid_cnt;
        pulse_poll();
        falls = 0;
        k = 0;
        p_prev = pad_if.famicom_pulse;
        while (falls < 4 && k < 200) begin
            @(negedge clk_sys);
            k++;
            if (p_prev && !pad_if.famicom_pulse) falls++;
            p_prev = pad_if.famicom_pulse;
        end
        check("reached_bit4", 32'(falls), 4);
        reset = 1'b1;
        @(negedge clk_sys);
        check("midrst_latch", 32'(pad_if.famicom_latch), 0);
        check("midrst_pulse", 32'(pad_if.famicom_pulse), 0);
        check("midrst_buttons", 32'(pad_if.buttons), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(pad_if.buttons_valid), 0);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (100) @(negedge clk_sys);
        check("no_partial_publish", 32'(valid_cnt - n0), 0);
        do_poll(8'h0F, {1'b1, 8'hF0});

        // Alternating all-pressed / none-pressed frames.
        do_poll(8'h00, {1'b1, 8'hFF});
        do_poll(8'hFF, {1'b1, 8'h00});
        do_poll(8'h00, {1'b1, 8'hFF});
        do_poll(8'hFF, {1'b1, 8'h00});

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
